// File: rtl/ycc_block_scheduler_if.sv
// Requester-side and result-side handshake bundle for ycc_block_scheduler.
// master: the block sources / result sink; slave: the scheduler itself.
interface ycc_block_scheduler_if #(
  parameter int N_REQ = 2
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]     in_valid;
  logic [N_REQ-1:0]     in_ready;
  logic [N_REQ*512-1:0] in_r;
  logic [N_REQ*512-1:0] in_g;
  logic [N_REQ*512-1:0] in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [1023:0]        out_y;
  logic [ID_W-1:0]      out_id;
  logic                 out_err;

  modport master (
    output in_valid, in_r, in_g, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_id, out_err
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, out_ready,
    output in_ready, out_valid, out_y, out_id, out_err
  );
endinterface

// File: rtl/ycc_block_scheduler.sv
// Round-robin scheduler sharing one 8x8 RGB->Y engine between N_REQ sources.
// Latches the granted block, pulses the engine start, waits for a rising
// finished edge, and returns the Y block tagged with the requester id. A
// watchdog pulses the engine reset when it hangs and returns an error result.
module ycc_block_scheduler #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ycc_block_scheduler_if.slave bus,
  output logic                 eng_start,
  output logic [511:0]         eng_r,
  output logic [511:0]         eng_g,
  output logic [511:0]         eng_b,
  input  logic [1023:0]        eng_y,
  input  logic                 eng_finished,
  output logic                 eng_rst_n,
  output logic                 busy,
  output logic [15:0]          blocks_done
);
  localparam int          ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          CW      = ID_W + 1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RC_LAST = 32'(RECOVER_CYCLES - 1);
  localparam logic [31:0] RC_DONE = 32'(RECOVER_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RECOVER = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      rcnt_q, rcnt_d;
  logic             hold_q, hold_d;
  logic             fin_q, fin_d;
  logic             eng_start_q, eng_start_d;
  logic [511:0]     eng_r_q, eng_r_d;
  logic [511:0]     eng_g_q, eng_g_d;
  logic [511:0]     eng_b_q, eng_b_d;
  logic             out_valid_q, out_valid_d;
  logic [1023:0]    out_y_q, out_y_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic             out_err_q, out_err_d;
  logic             busy_q, busy_d;
  logic [15:0]      blocks_done_q, blocks_done_d;

  logic             found_s;
  logic [ID_W-1:0]  grant_id_s;
  logic [N_REQ-1:0] grant_oh_s;
  logic [ID_W-1:0]  next_ptr_s;
  logic [CW-1:0]    cand_s;
  logic [CW-1:0]    nxt_s;

  // Round-robin search for the first valid requester starting at ptr
  always_comb begin
    found_s    = 1'b0;
    grant_id_s = '0;
    cand_s     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = {1'b0, ptr_q} + CW'(i);
      if (cand_s >= CW'(N_REQ)) begin
        cand_s = cand_s - CW'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && bus.in_valid[cand_s[ID_W-1:0]]) begin
        found_s    = 1'b1;
        grant_id_s = cand_s[ID_W-1:0];
      end else begin
        found_s    = found_s;
      end
    end
    grant_oh_s = '0;
    if (found_s) begin
      grant_oh_s[grant_id_s] = 1'b1;
    end else begin
      grant_oh_s = '0;
    end
    nxt_s = {1'b0, grant_id_s} + CW'(1);
    if (nxt_s >= CW'(N_REQ)) begin
      nxt_s = '0;
    end else begin
      nxt_s = nxt_s;
    end
    next_ptr_s = nxt_s[ID_W-1:0];
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    rcnt_d        = rcnt_q;
    hold_d        = hold_q;
    fin_d         = eng_finished;
    eng_start_d   = 1'b0;
    eng_r_d       = eng_r_q;
    eng_g_d       = eng_g_q;
    eng_b_d       = eng_b_q;
    out_valid_d   = out_valid_q;
    out_y_d       = out_y_q;
    out_id_d      = out_id_q;
    out_err_d     = out_err_q;
    blocks_done_d = blocks_done_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          eng_r_d     = bus.in_r[grant_id_s*512 +: 512];
          eng_g_d     = bus.in_g[grant_id_s*512 +: 512];
          eng_b_d     = bus.in_b[grant_id_s*512 +: 512];
          out_id_d    = grant_id_s;
          ptr_d       = next_ptr_s;
          eng_start_d = 1'b1;
          state_d     = S_START;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_START: begin
        cnt_d   = 32'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only a rising edge counts: a level left high by the previous block is stale
        if (eng_finished && !fin_q) begin
          out_y_d     = eng_y;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (cnt_q == TO_LAST) begin
          out_y_d     = '0;
          out_err_d   = 1'b1;
          hold_d      = 1'b1;
          rcnt_d      = 32'd0;
          state_d     = S_RECOVER;
        end else begin
          cnt_d       = cnt_q + 32'd1;
        end
      end
      S_RECOVER: begin
        // Engine reset is released one cycle before the error result is presented
        if (rcnt_q == RC_DONE) begin
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          rcnt_d = rcnt_q + 32'd1;
          if (rcnt_q == RC_LAST) begin
            hold_d = 1'b0;
          end else begin
            hold_d = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d   = 1'b0;
          blocks_done_d = blocks_done_q + 16'd1;
          state_d       = S_IDLE;
        end else begin
          out_valid_d   = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        hold_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State register and registered outputs, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= 32'd0;
      rcnt_q        <= 32'd0;
      hold_q        <= 1'b0;
      fin_q         <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_r_q       <= '0;
      eng_g_q       <= '0;
      eng_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_y_q       <= '0;
      out_id_q      <= '0;
      out_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      blocks_done_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      rcnt_q        <= rcnt_d;
      hold_q        <= hold_d;
      fin_q         <= fin_d;
      eng_start_q   <= eng_start_d;
      eng_r_q       <= eng_r_d;
      eng_g_q       <= eng_g_d;
      eng_b_q       <= eng_b_d;
      out_valid_q   <= out_valid_d;
      out_y_q       <= out_y_d;
      out_id_q      <= out_id_d;
      out_err_q     <= out_err_d;
      busy_q        <= busy_d;
      blocks_done_q <= blocks_done_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE && !rst) ? grant_oh_s : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_err   = out_err_q;
  assign eng_start     = eng_start_q;
  assign eng_r         = eng_r_q;
  assign eng_g         = eng_g_q;
  assign eng_b         = eng_b_q;
  assign eng_rst_n     = ~rst & ~hold_q;
  assign busy          = busy_q;
  assign blocks_done   = blocks_done_q;
endmodule

// File: tb/tb_ycc_block_scheduler.sv
// Directed bench for ycc_block_scheduler with a behavioural RGB->Y engine
// and a scoreboard of expected results keyed to accepted blocks.
module tb_ycc_block_scheduler;
  localparam int N_REQ = 2;
  localparam int TO    = 100;
  localparam int RC    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          eng_start;
  logic [511:0]  eng_r, eng_g, eng_b;
  logic [1023:0] eng_y;
  logic          eng_finished;
  logic          eng_rst_n;
  logic          busy;
  logic [15:0]   blocks_done;

  ycc_block_scheduler_if #(.N_REQ(N_REQ)) bus ();

  ycc_block_scheduler #(
    .N_REQ(N_REQ), .TIMEOUT_CYCLES(TO), .RECOVER_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .eng_start(eng_start), .eng_r(eng_r), .eng_g(eng_g), .eng_b(eng_b),
    .eng_y(eng_y), .eng_finished(eng_finished), .eng_rst_n(eng_rst_n),
    .busy(busy), .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_starts  = 0;
  int n_rst_low = 0;

  typedef struct { int id; logic [1023:0] y; logic err; } exp_t;
  exp_t sbq[$];
  int   grants[$];
  exp_t mon_e;
  int   mon_id;
  logic [511:0] exp_r = '0;
  logic expect_timeout = 1'b0;

  // engine model controls and state
  logic          eng_hang = 1'b0;
  int            drop_dly = 0;
  int            lat      = 20;
  int            age      = 0;
  logic          run      = 1'b0;
  logic          fin_r    = 1'b0;
  logic [1023:0] cap_y    = '0;
  logic [1023:0] y_r      = '0;
  assign eng_y        = y_r;
  assign eng_finished = fin_r;

  function automatic logic [511:0] mk_chan(input int seed, input int step);
    logic [511:0] v;
    for (int i = 0; i < 64; i++) v[i*8 +: 8] = 8'((seed + i*step) % 256);
    return v;
  endfunction

  function automatic logic [1023:0] y_block(input logic [511:0] r, input logic [511:0] g,
                                            input logic [511:0] b);
    logic [1023:0] y;
    for (int i = 0; i < 64; i++)
      y[i*16 +: 16] = 16'(77*int'(r[i*8 +: 8]) + 150*int'(g[i*8 +: 8]) + 29*int'(b[i*8 +: 8]));
    return y;
  endfunction

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cycle counter for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural engine: Y after lat cycles, finished level held until the next start
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      run <= 1'b0; age <= 0; fin_r <= 1'b0;
    end else if (eng_start) begin
      run <= 1'b1; age <= 1;
      cap_y <= y_block(eng_r, eng_g, eng_b);
      if (drop_dly == 0) fin_r <= 1'b0;
    end else if (run) begin
      age <= age + 1;
      if (!eng_hang && age == lat) begin
        fin_r <= 1'b1; y_r <= cap_y; run <= 1'b0;
      end else if (age == drop_dly) begin
        fin_r <= 1'b0;
      end
    end
  end

  // scoreboard push on accept, pop on result handshake, invariants every cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start) n_starts++;
      if (!eng_rst_n) n_rst_low++;
      if (bus.in_valid == 2'b11)
        check("ready_not_twohot", 1024'($countones(bus.in_ready) <= 1), 1024'(1));
      if (busy && !eng_start) check("eng_r_stable", eng_r, exp_r);
      if ((bus.in_valid & bus.in_ready) != 2'b00) begin
        mon_id = bus.in_ready[1] ? 1 : 0;
        grants.push_back(mon_id);
        exp_r      = bus.in_r[mon_id*512 +: 512];
        mon_e.id   = mon_id;
        mon_e.err  = expect_timeout;
        mon_e.y    = expect_timeout ? '0 :
                     y_block(bus.in_r[mon_id*512 +: 512], bus.in_g[mon_id*512 +: 512],
                             bus.in_b[mon_id*512 +: 512]);
        sbq.push_back(mon_e);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_out", 1024'(1), 1024'(0));
        end else begin
          mon_e = sbq.pop_front();
          check("out_id", 1024'(bus.out_id), 1024'(mon_e.id));
          check("out_err", 1024'(bus.out_err), 1024'(mon_e.err));
          check("out_y", bus.out_y, mon_e.y);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int id, input int sr, input int sg, input int sb_, input int step);
    bus.in_r[id*512 +: 512] = mk_chan(sr, step);
    bus.in_g[id*512 +: 512] = mk_chan(sg, step);
    bus.in_b[id*512 +: 512] = mk_chan(sb_, step);
  endtask

  task automatic wait_busy(input string tag);
    int i = 0;
    while (!busy && i < 200) begin tick(); i++; end
    check({tag, "_accepted"}, 1024'(busy), 1024'(1));
  endtask

  task automatic wait_start(input string tag, output int t);
    int i = 0;
    while (!eng_start && i < 200) begin tick(); i++; end
    check({tag, "_start_seen"}, 1024'(eng_start), 1024'(1));
    t = cyc;
  endtask

  task automatic wait_ov(input string tag, input int budget, output int t);
    int i = 0;
    while (!bus.out_valid && i < budget) begin tick(); i++; end
    check({tag, "_out_valid_seen"}, 1024'(bus.out_valid), 1024'(1));
    t = cyc;
  endtask

  task automatic do_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_block(input string tag, input int id, input int sr, input int sg,
                           input int sb_, input int step, input int exp_dly);
    int ts, tov;
    set_req(id, sr, sg, sb_, step);
    bus.in_valid = 2'b00;
    bus.in_valid[id] = 1'b1;
    wait_busy(tag);
    bus.in_valid = 2'b00;
    wait_start(tag, ts);
    wait_ov(tag, 300, tov);
    check({tag, "_latency"}, 1024'(tov - ts - 1), 1024'(exp_dly));
    do_out();
  endtask

  initial begin
    int ts, tov, g0, rl0, s0, i;
    logic [1023:0] ey;
    bus.in_valid  = 2'b01;
    bus.in_r      = '0;
    bus.in_g      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // reset state, with a requester already valid
    tick(); tick();
    check("rst_in_ready", 1024'(bus.in_ready), 1024'(0));
    check("rst_eng_start", 1024'(eng_start), 1024'(0));
    check("rst_eng_rst_n", 1024'(eng_rst_n), 1024'(0));
    check("rst_out_valid", 1024'(bus.out_valid), 1024'(0));
    check("rst_out_y", bus.out_y, '0);
    check("rst_busy", 1024'(busy), 1024'(0));
    check("rst_blocks_done", 1024'(blocks_done), 1024'(0));
    bus.in_valid = 2'b00;
    rst = 1'b0;
    tick();
    check("eng_rst_n_released", 1024'(eng_rst_n), 1024'(1));

    // single requester 0, all pixels 0x80, engine latency 20
    run_block("single", 0, 128, 128, 128, 0, 21);
    check("single_starts", 1024'(n_starts), 1024'(1));
    check("single_blocks_done", 1024'(blocks_done), 1024'(1));
    check("single_idle", 1024'(busy), 1024'(0));

    // requester 1 alone, moves pointer back to 0
    run_block("req1", 1, 3, 90, 200, 5, 21);

    // both requesters continuously valid for 6 blocks
    set_req(0, 10, 20, 30, 3);
    set_req(1, 250, 7, 99, 11);
    g0 = grants.size();
    bus.out_ready = 1'b1;
    bus.in_valid  = 2'b11;
    i = 0;
    while (grants.size() < g0 + 6 && i < 2000) begin tick(); i++; end
    bus.in_valid = 2'b00;
    check("rr_six_grants", 1024'(grants.size() - g0), 1024'(6));
    i = 0;
    while (busy && i < 200) begin tick(); i++; end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++)
      check("rr_grant_order", 1024'(grants[g0 + k]), 1024'(k % 2));

    // result held while out_ready stays low for 50 cycles
    set_req(0, 41, 77, 5, 13);
    ey = y_block(mk_chan(41, 13), mk_chan(77, 13), mk_chan(5, 13));
    bus.in_valid = 2'b01;
    wait_busy("hold");
    wait_start("hold", ts);
    wait_ov("hold", 300, tov);
    s0 = n_starts;
    for (int k = 0; k < 50; k++) begin
      check("hold_out_valid", 1024'(bus.out_valid), 1024'(1));
      check("hold_out_y", bus.out_y, ey);
      check("hold_out_id", 1024'(bus.out_id), 1024'(0));
      check("hold_in_ready", 1024'(bus.in_ready), 1024'(0));
      tick();
    end
    check("hold_no_restart", 1024'(n_starts - s0), 1024'(0));
    bus.in_valid = 2'b00;
    do_out();

    // hung engine: watchdog, recovery reset, error result
    eng_hang = 1'b1;
    expect_timeout = 1'b1;
    set_req(1, 60, 61, 62, 1);
    bus.in_valid = 2'b10;
    wait_busy("timeout");
    bus.in_valid = 2'b00;
    wait_start("timeout", ts);
    rl0 = n_rst_low;
    wait_ov("timeout", 400, tov);
    check("timeout_latency", 1024'(tov - ts - 1), 1024'(TO + RC + 1));
    check("timeout_rst_low_cycles", 1024'(n_rst_low - rl0), 1024'(RC));
    check("timeout_out_err", 1024'(bus.out_err), 1024'(1));
    check("timeout_out_y", bus.out_y, '0);
    check("timeout_eng_rst_n", 1024'(eng_rst_n), 1024'(1));
    do_out();
    eng_hang = 1'b0;
    expect_timeout = 1'b0;
    run_block("after_recover", 0, 9, 8, 7, 2, 21);

    // stale finished level: falls 3 cycles after start, rises at 10
    drop_dly = 3;
    lat = 10;
    run_block("stale_fin", 1, 33, 66, 99, 4, 11);
    drop_dly = 0;
    lat = 20;
    check("blocks_done_total", 1024'(blocks_done), 1024'(12));

    // reset in the middle of WAIT
    set_req(0, 100, 110, 120, 1);
    bus.in_valid = 2'b01;
    wait_busy("midrst");
    bus.in_valid = 2'b00;
    wait_start("midrst", ts);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    sbq.delete();
    check("midrst_busy", 1024'(busy), 1024'(0));
    check("midrst_eng_rst_n", 1024'(eng_rst_n), 1024'(0));
    check("midrst_eng_r", 1024'(eng_r), '0);
    check("midrst_out_valid", 1024'(bus.out_valid), 1024'(0));
    check("midrst_out_id", 1024'(bus.out_id), 1024'(0));
    check("midrst_out_err", 1024'(bus.out_err), 1024'(0));
    check("midrst_blocks_done", 1024'(blocks_done), 1024'(0));
    set_req(1, 1, 2, 3, 1);
    bus.in_valid = 2'b11;
    #1;
    check("midrst_in_ready", 1024'(bus.in_ready), 1024'(0));
    tick(); tick();
    rst = 1'b0;
    #1;
    check("after_rst_grant0", 1024'(bus.in_ready), 1024'(1));
    wait_busy("after_rst");
    bus.in_valid = 2'b00;
    wait_start("after_rst", ts);
    wait_ov("after_rst", 300, tov);
    check("after_rst_latency", 1024'(tov - ts - 1), 1024'(21));
    check("after_rst_id", 1024'(bus.out_id), 1024'(0));
    do_out();
    check("after_rst_blocks_done", 1024'(blocks_done), 1024'(1));
    check("sb_drained", 1024'(sbq.size()), 1024'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ycc_block_scheduler.md
# ycc_block_scheduler

Round-robin scheduler that shares one RGB→Y conversion `wrapper` engine (64-pixel 8x8 block, start/finished handshake) between `N_REQ` block sources. It accepts one RGB block at a time via valid/ready, drives the engine's `start`/`R`/`G`/`B`, detects completion, and returns the 64x16-bit Y block tagged with requester ID. A watchdog recovers a hung engine by pulsing its reset.

## Interface
- `N_REQ`, 2: number of requesters (2..8)
- `TIMEOUT_CYCLES`, 1000000: WAIT cycles before watchdog fires
- `RECOVER_CYCLES`, 4: cycles `eng_rst_n` held low on recovery
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in N_REQ: per-requester block valid
- `in_ready` out N_REQ: per-requester accept (one-hot or zero)
- `in_r`, `in_g`, `in_b` in N_REQ*512 each: requester k at `[k*512 +: 512]`, pixel i at `[i*8 +: 8]`
- `eng_start` out 1: one-cycle start pulse to engine
- `eng_r`, `eng_g`, `eng_b` out 512 each: latched block, stable from START until return to IDLE
- `eng_y` in 1024: engine Y output, pixel i at `[i*16 +: 16]`
- `eng_finished` in 1: engine completion
- `eng_rst_n` out 1: engine reset, active-low
- `out_valid` out 1; `out_ready` in 1: result handshake
- `out_y` out 1024; `out_id` out clog2(N_REQ) (min 1); `out_err` out 1: result, source, timeout flag
- `busy` out 1: state != IDLE
- `blocks_done` out 16: count of completed handshakes, wraps at 0xFFFF→0

## Operation
- States: IDLE, START, WAIT, RECOVER, OUT.
- IDLE: grant = first `in_valid[k]` searching k = ptr, ptr+1, … mod N_REQ; `in_ready` = one-hot grant (combinational from `in_valid`, `ptr`). On accept: latch RGB into `eng_*`, latch id, `ptr` ← (id+1) mod N_REQ, go to START. No valid → stay.
- START: `eng_start`=1 for exactly this cycle; clear timeout counter; → WAIT.
- WAIT: `fin_q` = `eng_finished` registered. Completion = `eng_finished & ~fin_q` (rising edge; a stale high level from the previous block is ignored). On completion: `out_y` ← `eng_y`, `out_err` ← 0, → OUT. Else counter++; when counter reaches TIMEOUT_CYCLES-1 with no completion: `out_y` ← 0, `out_err` ← 1, → RECOVER.
- RECOVER: `eng_rst_n`=0 for RECOVER_CYCLES cycles, then → OUT.
- OUT: `out_valid`=1, `out_y`/`out_id`/`out_err` held stable until `out_valid & out_ready`; then `blocks_done`++, → IDLE.
- `eng_rst_n` = ~rst outside RECOVER; `in_ready` = 0 in every state except IDLE.
- Completion and timeout in the same cycle: completion wins.

## Timing
- Reset (async, any state): state IDLE, `ptr`=0, `in_ready`=0 while rst asserted, `eng_start`=0, `eng_r/g/b`=0, `eng_rst_n`=0, `out_valid`=0, `out_y`=0, `out_id`=0, `out_err`=0, `busy`=0, `blocks_done`=0, `fin_q`=0. Reset mid-block discards the block; no output produced.
- Accept at edge T → `eng_start` high during cycle T+1 → WAIT from T+2.
- Rising `eng_finished` sampled at edge F → `out_valid` high from F+1.
- `out_ready` high at edge O with `out_valid` → `busy`=0 and next accept possible at edge O+1. Minimum cycle per block = engine latency + 4.
- Timeout: `out_valid` rises TIMEOUT_CYCLES+RECOVER_CYCLES+1 cycles after WAIT entry.

## Test plan
- Single requester 0, all pixels R=G=B=0x80, engine model finishes 20 cycles after start → one `eng_start` pulse, `out_valid` 21 cycles after start edge, `out_id`=0, `out_err`=0, `out_y` equals model output, `blocks_done`=1.
- Both requesters continuously valid, 6 blocks → grant order 0,1,0,1,0,1; `in_ready` never two-hot; `eng_r` stable throughout every WAIT.
- `out_ready` held low 50 cycles in OUT → `out_y`/`out_id` unchanged, `in_ready`=0, no second `eng_start`.
- Engine never finishes, TIMEOUT_CYCLES=100 → `eng_rst_n` low exactly 4 cycles, then `out_valid` with `out_err`=1, `out_y`=0; next block completes normally.
- `eng_finished` left high from prior block and falls 3 cycles after start, rises at 10 → completion taken at the rise only.
- `rst` asserted mid-WAIT → all outputs at reset values immediately (asynchronously); after release, requester 0 is granted first, `blocks_done`=0.
